// File: rtl/cmem_arbiter.sv
// cmem_arbiter: round-robin arbiter sharing one layer-memory port among
// three requesters (0 conv, 1 max-pool, 2 host) with locked multi-beat
// ownership, a starvation guard and 2-cycle read-data return routing.
// Ports: clk, reset (sync, active-low); req/lock/we[3], sel[9],
//   addr[3*AW], wdata[3*DW] in; gnt[3] (comb), rvalid[3], rdata[DW],
//   arb_busy out; memory side crd, cwr, csel, caddr_rd, caddr_wr,
//   cdata_wr out, cdata_rd in.
// Build option: define CMEM_FIXED_PRIO_EN for fixed 0>1>2 priority in
//   the free state (no rotation pointer); lock handling is unchanged.
module cmem_arbiter #(
  parameter int AW       = 12,
  parameter int DW       = 20,
  parameter int LOCK_MAX = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      req,
  input  logic [2:0]      lock,
  input  logic [2:0]      we,
  input  logic [8:0]      sel,
  input  logic [3*AW-1:0] addr,
  input  logic [3*DW-1:0] wdata,
  output logic [2:0]      gnt,
  output logic [2:0]      rvalid,
  output logic [DW-1:0]   rdata,
  output logic            arb_busy,
  output logic            crd,
  output logic            cwr,
  output logic [2:0]      csel,
  output logic [AW-1:0]   caddr_rd,
  output logic [AW-1:0]   caddr_wr,
  output logic [DW-1:0]   cdata_wr,
  input  logic [DW-1:0]   cdata_rd
);

  localparam logic [0:0] ST_ARB    = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;
  localparam logic [7:0] LMAX      = 8'(LOCK_MAX);

  logic [0:0]    r_state;
  logic [1:0]    r_owner;
  logic [7:0]    r_cnt;
  logic          r_p1_v;
  logic [1:0]    r_p1_id;
  logic          r_p2_v;
  logic [1:0]    r_p2_id;

  logic [2:0]    w_gnt;
  logic          w_acc;
  logic [1:0]    w_idx;
  logic          w_we;
  logic          w_lock;
  logic [2:0]    w_sel;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic [7:0]    w_cnt_nxt;
  logic          w_unlock;

`ifndef CMEM_FIXED_PRIO_EN
  logic [1:0]    r_ptr;
  logic [1:0]    w_o0;
  logic [1:0]    w_o1;
  logic [1:0]    w_o2;

  // Scan order starts one past the last granted requester.
  always_comb begin
    w_o0 = 2'd0;
    w_o1 = 2'd1;
    w_o2 = 2'd2;
    case (r_ptr)
      2'd0: begin
        w_o0 = 2'd1; w_o1 = 2'd2; w_o2 = 2'd0;
      end
      2'd1: begin
        w_o0 = 2'd2; w_o1 = 2'd0; w_o2 = 2'd1;
      end
      default: ;
    endcase
  end
`endif

  always_comb begin
    w_gnt = 3'b000;
    if (!reset) begin
      w_gnt = 3'b000;
    end else if (r_state == ST_LOCKED) begin
      // Others stay blocked even while the owner idles.
      w_gnt = req & (3'b001 << r_owner);
    end else begin
`ifdef CMEM_FIXED_PRIO_EN
      if (req[0])      w_gnt = 3'b001;
      else if (req[1]) w_gnt = 3'b010;
      else if (req[2]) w_gnt = 3'b100;
`else
      if (req[w_o0])      w_gnt = 3'b001 << w_o0;
      else if (req[w_o1]) w_gnt = 3'b001 << w_o1;
      else if (req[w_o2]) w_gnt = 3'b001 << w_o2;
`endif
    end
  end

  assign gnt     = w_gnt;
  assign w_acc   = |(req & w_gnt);
  assign w_idx   = w_gnt[2] ? 2'd2 : (w_gnt[1] ? 2'd1 : 2'd0);
  assign w_we    = |(we & w_gnt);
  assign w_lock  = |(lock & w_gnt);
  assign w_sel   = sel[3*w_idx +: 3];
  assign w_addr  = addr[AW*w_idx +: AW];
  assign w_wdata = wdata[DW*w_idx +: DW];

  assign w_cnt_nxt = r_cnt + 8'd1;
  // Leave the lock on an owner beat without lock, or at the cycle cap.
  assign w_unlock  = (w_cnt_nxt == LMAX) || (w_acc && !w_lock);

  assign arb_busy = (r_state == ST_LOCKED) | r_p1_v | r_p2_v;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= ST_ARB;
      r_owner  <= 2'd0;
      r_cnt    <= 8'd0;
      r_p1_v   <= 1'b0;
      r_p1_id  <= 2'd0;
      r_p2_v   <= 1'b0;
      r_p2_id  <= 2'd0;
      rvalid   <= 3'b000;
      rdata    <= '0;
      crd      <= 1'b0;
      cwr      <= 1'b0;
      csel     <= 3'd0;
      caddr_rd <= '0;
      caddr_wr <= '0;
      cdata_wr <= '0;
`ifndef CMEM_FIXED_PRIO_EN
      r_ptr    <= 2'd2;
`endif
    end else begin
      crd <= 1'b0;
      cwr <= 1'b0;
      if (w_acc) begin
        csel <= w_sel;
        if (w_we) begin
          cwr      <= 1'b1;
          caddr_wr <= w_addr;
          cdata_wr <= w_wdata;
        end else begin
          crd      <= 1'b1;
          caddr_rd <= w_addr;
        end
      end

      // Requester-ID pipeline: stage 1 = strobe out, stage 2 = data back.
      r_p1_v  <= w_acc & ~w_we;
      r_p1_id <= w_idx;
      r_p2_v  <= r_p1_v;
      r_p2_id <= r_p1_id;
      rvalid  <= 3'b000;
      if (r_p2_v) begin
        rvalid <= 3'b001 << r_p2_id;
        rdata  <= cdata_rd;
      end

`ifndef CMEM_FIXED_PRIO_EN
      if (w_acc) r_ptr <= w_idx;
`endif

      case (r_state)
        ST_ARB: begin
          if (w_acc && w_lock && (LMAX > 8'd1)) begin
            r_state <= ST_LOCKED;
            r_owner <= w_idx;
            r_cnt   <= 8'd1;
          end
        end
        default: begin
          r_cnt <= w_cnt_nxt;
          if (w_unlock) begin
            r_state <= ST_ARB;
            r_cnt   <= 8'd0;
`ifndef CMEM_FIXED_PRIO_EN
            r_ptr   <= r_owner;
`endif
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmem_arbiter.sv
// tb_cmem_arbiter: directed bench for cmem_arbiter with a memory model
// and a read-return scoreboard.
module tb_cmem_arbiter;

  localparam int AW = 12;
  localparam int DW = 20;

  logic            clk = 1'b0;
  logic            reset;
  logic [2:0]      req, lock, we;
  logic [8:0]      sel;
  logic [3*AW-1:0] addr;
  logic [3*DW-1:0] wdata;
  logic [2:0]      gnt, rvalid;
  logic [DW-1:0]   rdata;
  logic            arb_busy, crd, cwr;
  logic [2:0]      csel;
  logic [AW-1:0]   caddr_rd, caddr_wr;
  logic [DW-1:0]   cdata_wr;
  logic [DW-1:0]   cdata_rd = '0;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  typedef struct {
    logic [2:0]    oh;
    logic [DW-1:0] data;
    int            due;
  } rd_exp_t;
  rd_exp_t sb[$];

  logic [DW-1:0] mem [4096];
  logic          wr_hit [4096];

  cmem_arbiter dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .we(we),
    .sel(sel), .addr(addr), .wdata(wdata), .gnt(gnt),
    .rvalid(rvalid), .rdata(rdata), .arb_busy(arb_busy),
    .crd(crd), .cwr(cwr), .csel(csel), .caddr_rd(caddr_rd),
    .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .cdata_rd(cdata_rd)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_init(input logic [AW-1:0] a);
    return (a == 12'h041) ? 20'h0A5A5 : {8'h3C, a};
  endfunction

  // Memory: samples strobes one edge after the arbiter registers them.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cwr) begin
      mem[caddr_wr]    <= cdata_wr;
      wr_hit[caddr_wr] <= 1'b1;
    end
    if (crd)
      cdata_rd <= (wr_hit[caddr_rd] === 1'b1) ?
                  mem[caddr_rd] : mem_init(caddr_rd);
  end

  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      n_cmp++;
      assert (sb[0].due == cyc && rvalid === sb[0].oh &&
              rdata === sb[0].data)
      else begin
        n_err++;
        $error("FAIL rd_return observed=%b/%h expected=%b/%h",
               rvalid, rdata, sb[0].oh, sb[0].data);
      end
      void'(sb.pop_front());
    end else if (rvalid !== 3'b000) begin
      n_cmp++;
      assert (rvalid === 3'b000)
      else begin
        n_err++;
        $error("FAIL rd_spurious observed=%b expected=000", rvalid);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rq(input int i, input logic [2:0] s,
                        input logic [AW-1:0] a, input logic [DW-1:0] d);
    sel[3*i +: 3]     = s;
    addr[AW*i +: AW]  = a;
    wdata[DW*i +: DW] = d;
  endtask

  task automatic push_rd(input int i, input logic [AW-1:0] a);
    rd_exp_t e;
    e.oh   = 3'b001 << i;
    e.data = mem_init(a);
    e.due  = cyc + 3;
    sb.push_back(e);
  endtask

  initial begin
    logic [2:0] exp_g;
    reset = 1'b0;
    req = 3'b111; lock = 3'b000; we = 3'b111;
    sel = '0; addr = '0; wdata = '0;
    for (int i = 0; i < 3; i++)
      set_rq(i, 3'(i + 1), 12'h100 + 12'(i), 20'hA0000 + 20'(i));

    // Reset with all requesters active.
    tick();
    chk("gnt_in_reset", 32'(gnt), 32'h0);
    tick();
    chk("gnt_in_reset2", 32'(gnt), 32'h0);
    chk("rst_strobes", {crd, cwr, arb_busy, rvalid}, 32'h0);
    chk("rst_csel", 32'(csel), 32'h0);
    chk("rst_addr", {caddr_rd, caddr_wr}, 32'h0);
    chk("rst_data", {cdata_wr, rdata} != '0, 32'h0);

    // Round-robin writes.
    reset = 1'b1;
    #1;
    for (int t = 0; t < 6; t++) begin
      chk("rr_gnt", 32'(gnt), 32'(3'b001 << (t % 3)));
      tick();
      chk("rr_cwr", {crd, cwr}, 32'h1);
      chk("rr_caddr_wr", 32'(caddr_wr), 32'h100 + 32'(t % 3));
      chk("rr_csel", 32'(csel), 32'(t % 3 + 1));
      chk("rr_cdata_wr", 32'(cdata_wr), 32'hA0000 + 32'(t % 3));
    end
    req = 3'b000;
    tick();
    chk("idle_cwr", {crd, cwr}, 32'h0);

    // Single read by requester 1.
    we = 3'b000;
    set_rq(1, 3'd1, 12'h041, 20'h0);
    req = 3'b010;
    #1;
    chk("rd1_gnt", 32'(gnt), 32'h2);
    push_rd(1, 12'h041);
    tick();
    req = 3'b000;
    chk("rd1_crd", {crd, cwr}, 32'h2);
    chk("rd1_caddr_rd", 32'(caddr_rd), 32'h041);
    chk("rd1_busy", 32'(arb_busy), 32'h1);
    tick();
    tick();
    chk("rd1_rdata", 32'(rdata), 32'h0A5A5);
    tick();
    chk("rd1_hold", {rvalid, rdata}, {3'b000, 20'h0A5A5});
    chk("rd1_idle_busy", 32'(arb_busy), 32'h0);

    // Back-to-back reads from 0, 1, 2.
    for (int i = 0; i < 3; i++)
      set_rq(i, 3'(i), 12'h200 + 12'(i), 20'h0);
    for (int i = 0; i < 3; i++) begin
      req = 3'b001 << i;
      #1;
      chk("b2b_gnt", 32'(gnt), 32'(3'b001 << i));
      push_rd(i, 12'h200 + 12'(i));
      tick();
    end
    req = 3'b000;
    repeat (4) tick();

    // Requester 2 locked for 4 beats while requester 0 waits.
    we = 3'b100;
    set_rq(2, 3'd5, 12'h300, 20'h12345);
    for (int b = 0; b < 4; b++) begin
      req  = (b == 0) ? 3'b100 : 3'b101;
      lock = (b == 3) ? 3'b000 : 3'b100;
      #1;
      chk("lk_gnt", 32'(gnt), 32'h4);
      tick();
      chk("lk_cwr", 32'(cwr), 32'h1);
    end
    req = 3'b101;
    lock = 3'b000;
    #1;
    chk("lk_release_gnt", 32'(gnt), 32'h1);
    req = 3'b000;
    tick();

    // Starvation guard: requester 0 holds lock with requester 1 waiting.
    we = 3'b011;
    req = 3'b011;
    lock = 3'b001;
    for (int b = 0; b < 16; b++) begin
      #1;
      chk("sg_gnt", 32'(gnt), 32'h1);
      tick();
      if (b == 4) chk("sg_busy", 32'(arb_busy), 32'h1);
    end
    #1;
    chk("sg_switch_gnt", 32'(gnt), 32'h2);
    req = 3'b000;
    lock = 3'b000;
    tick();

    // Reset lands one edge after a read is accepted.
    we = 3'b000;
    set_rq(0, 3'd2, 12'h041, 20'h0);
    req = 3'b001;
    #1;
    chk("mr_gnt", 32'(gnt), 32'h1);
    tick();
    chk("mr_crd", 32'(crd), 32'h1);
    req = 3'b000;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("mr_rvalid", 32'(rvalid), 32'h0);
    chk("mr_rdata", 32'(rdata), 32'h0);
    chk("mr_busy", {crd, arb_busy}, 32'h0);

    // Requesters 1 and 2 contend; ptr restarts at 2 after reset.
    we = 3'b110;
    req = 3'b110;
    for (int t = 0; t < 4; t++) begin
`ifdef CMEM_FIXED_PRIO_EN
      exp_g = 3'b010;
`else
      exp_g = (t % 2 == 0) ? 3'b010 : 3'b100;
`endif
      #1;
      chk("p12_gnt", 32'(gnt), 32'(exp_g));
      tick();
    end
    req = 3'b000;
    repeat (4) tick();
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
